// File: rtl/param_cpu_pkg.sv
// param_cpu_pkg: opcode and state enumerations plus instruction field positions
// Used by param_cpu and param_cpu_alu.
package param_cpu_pkg;
  typedef enum logic [3:0] {
    OP_ADD, OP_ADD_I, OP_NAND, OP_NAND_I, OP_SRL, OP_SRL_I, OP_LT, OP_LT_I,
    OP_CP, OP_CP_I, OP_CPI, OP_CPI_I, OP_BZJ, OP_BZJ_I, OP_MUL, OP_MUL_I
  } op_e;
  typedef enum logic [2:0] {S_FETCH, S_RDA, S_RDB, S_IND, S_WB} state_e;
  function automatic int op_lsb(input int data_w);
    return data_w - 4;
  endfunction
  function automatic int a_lsb(input int addr_w);
    return addr_w;
  endfunction
endpackage

// File: rtl/param_cpu_alu.sv
// param_cpu_alu: combinational result datapath (add, nand, shift, compare, copy, mul)
// Ports: op opcode, x = *A, y = second operand (*B, zero-extended B, or **B), res result.
// Macro PARAM_CPU_MUL_EN builds the multiplier; without it the mul result is tied to zero.
module param_cpu_alu import param_cpu_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  output logic [DATA_W-1:0] res
);
  logic [DATA_W-1:0] shr, mul;
  always_comb begin
    // counts of DATA_W and above turn into a left shift by the excess
    shr = (y < DATA_W'(DATA_W)) ? x >> y : x << (y - DATA_W'(DATA_W));
`ifdef PARAM_CPU_MUL_EN
    mul = x * y;
`else
    mul = '0;
`endif
    res = (op inside {OP_ADD, OP_ADD_I})   ? x + y :
          (op inside {OP_NAND, OP_NAND_I}) ? ~(x & y) :
          (op inside {OP_SRL, OP_SRL_I})   ? shr :
          (op inside {OP_LT, OP_LT_I})     ? {{(DATA_W-1){1'b0}}, x < y} :
          (op inside {OP_MUL, OP_MUL_I})   ? mul : y;
  end
endmodule

// File: rtl/param_cpu.sv
// param_cpu: multi-cycle memory-to-memory CPU sequencer (FETCH/RDA/RDB/IND/WB)
// Ports: clk, rst (async active-low), run, mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ready
//        memory handshake, pc program counter, idle, retired completion count.
// Macro PARAM_CPU_MUL_EN enables MUL/MULi; otherwise they retire without writing.
module param_cpu import param_cpu_pkg::*; #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              idle,
  output logic [31:0]       retired
);
`ifdef PARAM_CPU_MUL_EN
  localparam logic MUL_EN = 1'b1;
`else
  localparam logic MUL_EN = 1'b0;
`endif
  state_e state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [ADDR_W-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d, pc_inc;
  logic [DATA_W-1:0] va_q, va_d, vb_q, vb_d, y, res;
  logic [31:0] ret_q, ret_d;
  logic pend_q, pend_d, req, ack, wb_wr, done;
  param_cpu_alu #(.DATA_W(DATA_W)) u_alu (.op(op_q), .x(va_q), .y(y), .res(res));
  always_comb begin
    pc_inc = pc_q + ADDR_W'(1);
    wb_wr = op_q != OP_BZJ_I && (MUL_EN || !(op_q inside {OP_MUL, OP_MUL_I}));
    y = op_q[0] ? DATA_W'(b_q) : vb_q;
    // pend_q keeps a stalled fetch alive if run drops while waiting
    req = (state_q == S_FETCH) ? (run | pend_q) : (state_q != S_WB) | wb_wr;
    ack = req & mem_ready;
    mem_req = rst & req;
    mem_we = (state_q == S_WB && wb_wr) || (state_q == S_IND && op_q == OP_CPI_I);
    mem_addr = (state_q == S_FETCH) ? pc_q :
               (state_q == S_RDB)   ? b_q :
               (state_q == S_IND)   ? (op_q == OP_CPI_I ? va_q[ADDR_W-1:0] : vb_q[ADDR_W-1:0]) : a_q;
    mem_wdata = (state_q == S_WB) ? res : (state_q == S_IND && op_q == OP_CPI_I) ? vb_q : '0;
    idle = state_q == S_FETCH && !run;
    pend_d = state_q == S_FETCH && req && !mem_ready;
    state_d = state_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    va_d = va_q;
    vb_d = vb_q;
    done = 1'b0;
    case (state_q)
      S_FETCH: if (ack) begin
        op_d = mem_rdata[op_lsb(DATA_W) +: 4];
        a_d = mem_rdata[a_lsb(ADDR_W) +: ADDR_W];
        b_d = mem_rdata[ADDR_W-1:0];
        state_d = S_RDA;
      end
      S_RDA: if (ack) begin
        va_d = mem_rdata;
        state_d = (op_q[0] && op_q != OP_CPI_I) ? S_WB : S_RDB;
      end
      S_RDB: if (ack) begin
        vb_d = mem_rdata;
        state_d = (op_q inside {OP_CPI, OP_CPI_I}) ? S_IND : (op_q == OP_BZJ) ? S_FETCH : S_WB;
        done = op_q == OP_BZJ;
      end
      S_IND: if (ack) begin
        vb_d = mem_rdata;
        state_d = (op_q == OP_CPI_I) ? S_FETCH : S_WB;
        done = op_q == OP_CPI_I;
      end
      default: if (ack || !req) begin
        state_d = S_FETCH;
        done = 1'b1;
      end
    endcase
    // BZJ completes in RDB, so mem_rdata there is *B
    pc_d = !done ? pc_q :
           (op_q == OP_BZJ)   ? (mem_rdata == '0 ? va_q[ADDR_W-1:0] : pc_inc) :
           (op_q == OP_BZJ_I) ? va_q[ADDR_W-1:0] + b_q : pc_inc;
    ret_d = done ? ret_q + 32'd1 : ret_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= S_FETCH;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      va_q <= '0;
      vb_q <= '0;
      pc_q <= '0;
      ret_q <= '0;
      pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      va_q <= va_d;
      vb_q <= vb_d;
      pc_q <= pc_d;
      ret_q <= ret_d;
      pend_q <= pend_d;
    end
  assign pc = pc_q;
  assign retired = ret_q;
endmodule

// File: tb/tb_param_cpu.sv
// tb_param_cpu: directed and randomized checks of param_cpu against an instruction-level model
module tb_param_cpu;
  import param_cpu_pkg::*;
`ifdef PARAM_CPU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  localparam int MEM_N = 16384;
  logic clk, rst, run, mem_req, mem_we, mem_ready, idle;
  logic [13:0] mem_addr, pc;
  logic [31:0] mem_wdata, mem_rdata, retired;
  logic [31:0] mem [0:MEM_N-1];
  logic [31:0] m [0:MEM_N-1];
  logic [13:0] mpc;
  logic [1:0] mode;
  logic sync, rnd_b, hold, h_we;
  logic [13:0] h_addr;
  logic [31:0] h_wd;
  int wcnt, stab_err, stab_chk, total, bad;

  param_cpu #(.ADDR_W(14), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .run(run), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .pc(pc), .idle(idle), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  assign mem_ready = (mode == 2'd0) ? 1'b1 : (mode == 2'd1) ? rnd_b : (wcnt == 2);

  initial begin
    wcnt = 0;
    stab_err = 0;
    stab_chk = 0;
    hold = 1'b0;
    rnd_b = 1'b0;
  end

  always @(posedge clk) begin
    rnd_b <= $urandom_range(0, 1) == 1;
    if (sync) begin
      for (int i = 0; i < MEM_N; i++) mem[i] <= m[i];
      wcnt <= 0;
    end else if (mem_req && mem_ready) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      wcnt <= 0;
    end else if (mem_req) wcnt <= wcnt + 1;
    hold <= rst && mem_req && !mem_ready;
    h_addr <= mem_addr;
    h_we <= mem_we;
    h_wd <= mem_wdata;
    if (hold && rst) begin
      stab_chk <= stab_chk + 1;
      if ({mem_req, mem_addr, mem_we, mem_wdata} !== {1'b1, h_addr, h_we, h_wd}) stab_err <= stab_err + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ins(input logic [3:0] op, input int a, input int b);
    return {op, a[13:0], b[13:0]};
  endfunction

  task automatic clear_m();
    for (int i = 0; i < MEM_N; i++) m[i] = '0;
  endtask

  task automatic boot(input logic [1:0] md);
    rst = 1'b0;
    run = 1'b0;
    mode = md;
    sync = 1'b1;
    @(posedge clk);
    #1;
    sync = 1'b0;
  endtask

  task automatic go(input int n, input int lim, output int cyc);
    cyc = 0;
    rst = 1'b1;
    run = 1'b1;
    while (retired != n && cyc < lim) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    run = 1'b0;
  endtask

  // one instruction, straight from the architectural definition
  task automatic model_step();
    logic [31:0] w, va, vb, y, r;
    logic [3:0] op;
    logic [13:0] a, b, npc;
    bit wr;
    w = m[mpc];
    op = w[31:28];
    a = w[27:14];
    b = w[13:0];
    va = m[a];
    vb = m[b];
    y = op[0] ? {18'd0, b} : vb;
    npc = mpc + 14'd1;
    wr = 1'b1;
    r = '0;
    case (op[3:1])
      3'd0: r = va + y;
      3'd1: r = ~(va & y);
      3'd2: r = (y < 32) ? va >> y : va << (y - 32);
      3'd3: r = (va < y) ? 32'd1 : 32'd0;
      3'd4: r = y;
      3'd5: if (op[0]) begin
        m[va[13:0]] = vb;
        wr = 1'b0;
      end else r = m[vb[13:0]];
      3'd6: begin
        wr = 1'b0;
        npc = op[0] ? va[13:0] + b : (vb == 0 ? va[13:0] : npc);
      end
      default: if (MUL_EN) r = va * y; else wr = 1'b0;
    endcase
    if (wr) m[a] = r;
    mpc = npc;
  endtask

  initial begin
    int cyc, diff;
    total = 0;
    bad = 0;
    mode = 2'd0;
    sync = 1'b0;
    rst = 1'b0;
    run = 1'b1;
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 0);
    chk("rst_pc", {18'd0, pc}, 0);
    chk("rst_retired", retired, 0);
    chk("rst_mem_we", {31'd0, mem_we}, 0);
    // ADDi, ready tied high: three cycles
    clear_m();
    m[0] = ins(OP_ADD_I, 5, 3);
    m[5] = 7;
    boot(2'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_run0", {31'd0, idle}, 1);
    chk("idle_req", {31'd0, mem_req}, 0);
    go(1, 50, cyc);
    chk("addi_cycles", cyc, 3);
    chk("addi_mem", mem[5], 10);
    chk("addi_pc", {18'd0, pc}, 1);
    chk("addi_retired", retired, 1);
    // run dropped mid-instruction still completes, then idles
    boot(2'd0);
    rst = 1'b1;
    run = 1'b1;
    @(posedge clk);
    #1;
    run = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("drop_retired", retired, 1);
    chk("drop_idle", {31'd0, idle}, 1);
    chk("drop_req", {31'd0, mem_req}, 0);
    chk("drop_mem", mem[5], 10);
    // SRL by 31 then 33
    clear_m();
    m[0] = ins(OP_SRL, 5, 6);
    m[5] = 32'h8000_0000;
    m[6] = 31;
    boot(2'd0);
    go(1, 50, cyc);
    chk("srl31", mem[5], 1);
    chk("srl_cycles", cyc, 4);
    m[6] = 33;
    boot(2'd0);
    go(1, 50, cyc);
    chk("srl33", mem[5], 0);
    // BZJ taken / not taken
    clear_m();
    m[0] = ins(OP_BZJ, 5, 6);
    m[5] = 32'h2000;
    m[6] = 0;
    boot(2'd0);
    go(1, 50, cyc);
    chk("bzj_taken", {18'd0, pc}, 32'h2000);
    chk("bzj_cycles", cyc, 3);
    m[6] = 5;
    boot(2'd0);
    go(1, 50, cyc);
    chk("bzj_fall", {18'd0, pc}, 1);
    // CPI with two wait cycles per access
    clear_m();
    m[0] = ins(OP_CPI, 5, 6);
    m[6] = 20;
    m[20] = 32'hABCD;
    boot(2'd2);
    go(1, 100, cyc);
    chk("cpi_val", mem[5], 32'hABCD);
    chk("cpi_cycles", cyc, 15);
    chk("cpi_stable", stab_err, 0);
    // reset during the WB wait of ADD
    clear_m();
    m[0] = ins(OP_ADD, 5, 6);
    m[5] = 1;
    m[6] = 2;
    boot(2'd2);
    rst = 1'b1;
    run = 1'b1;
    cyc = 0;
    while (!(mem_req && mem_we) && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("rstwb_reached", {31'd0, mem_we}, 1);
    #1;
    rst = 1'b0;
    run = 1'b0;
    #1;
    chk("rstwb_req", {31'd0, mem_req}, 0);
    chk("rstwb_pc", {18'd0, pc}, 0);
    chk("rstwb_retired", retired, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("rstwb_nowrite", mem[5], 1);
    // MUL under the current macro setting
    clear_m();
    m[0] = ins(OP_MUL, 5, 6);
    m[5] = 32'h10000;
    m[6] = 32'h10000;
    boot(2'd0);
    go(1, 50, cyc);
    chk("mul_mem", mem[5], MUL_EN ? 32'h0 : 32'h10000);
    chk("mul_pc", {18'd0, pc}, 1);
    chk("mul_retired", retired, 1);
    // branch to itself keeps retiring
    clear_m();
    m[0] = ins(OP_BZJ_I, 5, 0);
    boot(2'd0);
    go(3, 50, cyc);
    chk("spin_cycles", cyc, 9);
    chk("spin_pc", {18'd0, pc}, 0);
    // jump target truncation and pc wrap
    clear_m();
    m[0] = ins(OP_BZJ_I, 5, 0);
    m[5] = 32'hFFFF_FFFF;
    m[14'h3FFF] = ins(OP_ADD_I, 7, 1);
    m[7] = 4;
    boot(2'd0);
    go(2, 50, cyc);
    chk("wrap_pc", {18'd0, pc}, 0);
    chk("wrap_mem", mem[7], 5);
    // random programs against the model, ready tied high and random
    for (int md = 0; md < 2; md++) begin
      for (int i = 0; i < MEM_N; i++) m[i] = $urandom;
      boot(md[1:0]);
      mpc = '0;
      repeat (400) model_step();
      go(400, 40000, cyc);
      chk("rand_retired", retired, 400);
      chk("rand_pc", {18'd0, pc}, {18'd0, mpc});
      diff = 0;
      for (int i = 0; i < MEM_N; i++) if (mem[i] !== m[i]) diff++;
      chk("rand_mem", diff, 0);
    end
    chk("stable_all", stab_err, 0);
    chk("stable_seen", {31'd0, stab_chk > 0}, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
